// File: rtl/pc_redirect_ctrl.sv
// PC sequencer and control-flow redirect controller: advances, holds or loads the
// branch target, pulses pipeline flushes after a redirect, halts on a misaligned target.
module pc_redirect_ctrl #(
  parameter int PC_W = 9
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Stall,
  input  logic            ExValid,
  input  logic            PcSel,
  input  logic [31:0]     BrPC,
  output logic [PC_W-1:0] PC,
  output logic            Flush_IF_ID,
  output logic            Flush_ID_EX,
  output logic            Redirect,
  output logic            MisalignErr,
  output logic [15:0]     RedirectCount
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic            r_flush;
  logic            r_err;
  logic [15:0]     r_cnt;

  logic            w_take;
  logic            w_aligned;
  logic [PC_W-1:0] w_pc_inc;
  logic            w_unused_hi;

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  assign w_take      = PcSel && ExValid;
  assign w_aligned   = (BrPC[1:0] == 2'b00);
  assign w_pc_inc    = r_pc + PC_W'(4);
  // Target bits above the PC width are intentionally discarded.
  assign w_unused_hi = ^BrPC[31:PC_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RUN;
      r_pc    <= '0;
      r_flush <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_flush <= 1'b0;
      unique case (r_state)
        RUN: begin
          if (w_take && !w_aligned) begin
            r_err   <= 1'b1;
            r_state <= HALT;
          end else if (w_take) begin
            r_pc    <= BrPC[PC_W-1:0];
            r_state <= FLUSH;
            r_flush <= 1'b1;
            r_cnt   <= sat_inc(r_cnt);
          end else if (!Stall) begin
            r_pc <= w_pc_inc;
          end
        end
        // The instruction in EX is wrong-path here, so its PcSel is dropped.
        FLUSH: begin
          r_state <= RUN;
          if (!Stall) r_pc <= w_pc_inc;
        end
        HALT: begin
          r_state <= HALT;
        end
        default: r_state <= RUN;
      endcase
    end
  end

  assign PC            = r_pc;
  assign Flush_IF_ID   = r_flush;
  assign Flush_ID_EX   = r_flush;
  assign Redirect      = r_flush;
  assign MisalignErr   = r_err;
  assign RedirectCount = r_cnt;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Scoreboard bench for pc_redirect_ctrl: the driver queues the expected post-edge
// outputs for each vector, the monitor pops and compares one entry after each edge.
module tb_pc_redirect_ctrl;

  logic        clk = 1'b0;
  logic        reset, Stall, ExValid, PcSel;
  logic [31:0] BrPC;
  logic [8:0]  PC;
  logic        Flush_IF_ID, Flush_ID_EX, Redirect, MisalignErr;
  logic [15:0] RedirectCount;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [8:0]  pc;
    logic        fl;
    logic        err;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  pc_redirect_ctrl #(.PC_W(9)) dut (
    .clk          (clk),
    .reset        (reset),
    .Stall        (Stall),
    .ExValid      (ExValid),
    .PcSel        (PcSel),
    .BrPC         (BrPC),
    .PC           (PC),
    .Flush_IF_ID  (Flush_IF_ID),
    .Flush_ID_EX  (Flush_ID_EX),
    .Redirect     (Redirect),
    .MisalignErr  (MisalignErr),
    .RedirectCount(RedirectCount)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Drive one vector at the falling edge; its effect is visible after the next rising edge.
  task automatic step(input logic rst, input logic st, input logic ev, input logic ps,
                      input logic [31:0] br, input logic [8:0] epc, input logic efl,
                      input logic eerr, input logic [15:0] ecnt);
    exp_t e;
    @(negedge clk);
    reset = rst; Stall = st; ExValid = ev; PcSel = ps; BrPC = br;
    e.pc = epc; e.fl = efl; e.err = eerr; e.cnt = ecnt;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("PC", 32'(PC), 32'(e.pc));
        chk("Flush_IF_ID", 32'(Flush_IF_ID), 32'(e.fl));
        chk("Flush_ID_EX", 32'(Flush_ID_EX), 32'(e.fl));
        chk("Redirect", 32'(Redirect), 32'(e.fl));
        chk("MisalignErr", 32'(MisalignErr), 32'(e.err));
        chk("RedirectCount", 32'(RedirectCount), 32'(e.cnt));
      end
    end
  end

  initial begin : driver
    reset = 1'b1; Stall = 1'b0; ExValid = 1'b0; PcSel = 1'b0; BrPC = '0;

    // reset for two cycles
    step(1, 0, 0, 0, 32'h0, 9'd0, 0, 0, 16'd0);
    step(1, 1, 1, 1, 32'h40, 9'd0, 0, 0, 16'd0);

    // free run, wrapping 508 -> 0 and stopping at PC = 16
    for (int k = 1; k <= 132; k++)
      step(0, 0, 0, 0, 32'h0, 9'((4 * k) % 512), 0, 0, 16'd0);

    // taken branch to 0x40
    step(0, 0, 1, 1, 32'h40, 9'd64, 1, 0, 16'd1);
    step(0, 0, 0, 0, 32'h0, 9'd68, 0, 0, 16'd1);

    // redirect overrides stall; stall held through FLUSH keeps the target
    step(0, 1, 1, 1, 32'h100, 9'd256, 1, 0, 16'd2);
    step(0, 1, 0, 0, 32'h0, 9'd256, 0, 0, 16'd2);
    step(0, 0, 0, 0, 32'h0, 9'd260, 0, 0, 16'd2);
    step(0, 1, 0, 0, 32'h0, 9'd260, 0, 0, 16'd2);

    // back-to-back PcSel: the second one lands in FLUSH and is dropped
    step(0, 0, 1, 1, 32'h20, 9'd32, 1, 0, 16'd3);
    step(0, 0, 1, 1, 32'h80, 9'd36, 0, 0, 16'd3);
    step(0, 0, 0, 0, 32'h0, 9'd40, 0, 0, 16'd3);

    // PcSel without ExValid has no effect, aligned or not
    step(0, 0, 0, 1, 32'h100, 9'd44, 0, 0, 16'd3);
    step(0, 0, 0, 1, 32'h42, 9'd48, 0, 0, 16'd3);

    // upper target bits discarded: 0x1204 -> 0x004
    step(0, 0, 1, 1, 32'h0000_1204, 9'd4, 1, 0, 16'd4);
    step(0, 0, 0, 0, 32'h0, 9'd8, 0, 0, 16'd65533);
    // preload the counter close to saturation for the edge just queued above
    #1 force dut.r_cnt = 16'hFFFD;
    #1 release dut.r_cnt;

    step(0, 0, 1, 1, 32'h40, 9'd64, 1, 0, 16'hFFFE);
    step(0, 0, 0, 0, 32'h0, 9'd68, 0, 0, 16'hFFFE);
    step(0, 0, 1, 1, 32'h80, 9'd128, 1, 0, 16'hFFFF);
    step(0, 0, 0, 0, 32'h0, 9'd132, 0, 0, 16'hFFFF);
    step(0, 0, 1, 1, 32'h40, 9'd64, 1, 0, 16'hFFFF);
    step(0, 0, 0, 0, 32'h0, 9'd68, 0, 0, 16'hFFFF);

    // misaligned target: hold PC, raise sticky error, freeze until reset
    step(0, 0, 1, 1, 32'h42, 9'd68, 0, 1, 16'hFFFF);
    step(0, 1, 1, 1, 32'h100, 9'd68, 0, 1, 16'hFFFF);
    step(0, 0, 1, 1, 32'h40, 9'd68, 0, 1, 16'hFFFF);
    step(0, 0, 0, 0, 32'h0, 9'd68, 0, 1, 16'hFFFF);
    step(1, 0, 1, 1, 32'h42, 9'd0, 0, 0, 16'd0);
    step(0, 0, 0, 0, 32'h0, 9'd4, 0, 0, 16'd0);

    // reset in the middle of FLUSH wins
    step(0, 0, 1, 1, 32'h40, 9'd64, 1, 0, 16'd1);
    step(1, 0, 1, 1, 32'h80, 9'd0, 0, 0, 16'd0);
    step(0, 0, 0, 0, 32'h0, 9'd4, 0, 0, 16'd0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
